// File: rtl/fdb_learn_table.sv
// Self-learning MAC forwarding table: DMAC lookup -> egress port mask, SMAC learning, aging, flush.
// Response 3 edges after accept; one request per 4 cycles; rsp held until rsp_ready, req_ready low while busy.
module fdb_learn_table #(
  parameter int NPORTS    = 4,
  parameter int PORT_W    = 2,
  parameter int DEPTH     = 16,
  parameter int AGE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [47:0]       req_dmac,
  input  logic [47:0]       req_smac,
  input  logic [PORT_W-1:0] req_src_port,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [NPORTS-1:0] rsp_port_mask,
  output logic              rsp_hit,
  input  logic              age_tick,
  input  logic              flush,
  output logic              learn_drop,
  output logic [6:0]        entry_count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [3:0] AGE_MAX = 4'(AGE_LIMIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_MATCH, S_LEARN, S_RESP} state_t;
  state_t state;

  logic [DEPTH-1:0]  ent_valid;
  logic [3:0]        ent_age  [DEPTH];
  logic [47:0]       ent_mac  [DEPTH];
  logic [PORT_W-1:0] ent_port [DEPTH];

  logic [47:0]       dmac_q, smac_q;
  logic [PORT_W-1:0] src_q;

  // MATCH-time snapshot: lookup result and learn target
  logic              dhit_q, shit_q, free_q;
  logic [PORT_W-1:0] dport_q;
  logic [IDX_W-1:0]  shit_idx_q, free_idx_q;

  logic              dhit_c, shit_c, free_c;
  logic [PORT_W-1:0] dport_c;
  logic [IDX_W-1:0]  shit_idx_c, free_idx_c;

  logic              learn_ok, wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [NPORTS-1:0] src_oh, dport_oh, mask_c;
  logic              hit_c;
  logic [6:0]        cnt_c;

  // Descending scan so the lowest matching / free index wins
  always_comb begin
    dhit_c     = 1'b0;
    shit_c     = 1'b0;
    free_c     = 1'b0;
    dport_c    = '0;
    shit_idx_c = '0;
    free_idx_c = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ent_valid[i] && ent_mac[i] == dmac_q) begin
        dhit_c  = 1'b1;
        dport_c = ent_port[i];
      end
      if (ent_valid[i] && ent_mac[i] == smac_q) begin
        shit_c     = 1'b1;
        shit_idx_c = IDX_W'(i);
      end
      if (!ent_valid[i]) begin
        free_c     = 1'b1;
        free_idx_c = IDX_W'(i);
      end
    end
  end

  assign learn_ok   = !smac_q[40] && (smac_q != 48'h0);
  assign wr_en      = reset && (state == S_LEARN) && learn_ok && (shit_q || free_q) && !flush;
  assign wr_idx     = shit_q ? shit_idx_q : free_idx_q;
  assign learn_drop = reset && (state == S_LEARN) && learn_ok && !shit_q && !free_q && !flush;

  always_comb begin
    src_oh   = '0;
    dport_oh = '0;
    for (int p = 0; p < NPORTS; p++) begin
      src_oh[p]   = (src_q == PORT_W'(p));
      dport_oh[p] = (dport_q == PORT_W'(p));
    end
    mask_c = ~src_oh;
    hit_c  = 1'b0;
    if (!dmac_q[40] && dhit_q) begin
      hit_c  = 1'b1;
      mask_c = (dport_q == src_q) ? '0 : dport_oh;
    end
  end

  always_comb begin
    cnt_c = '0;
    for (int i = 0; i < DEPTH; i++) cnt_c = cnt_c + {6'b0, ent_valid[i]};
  end

  // Per-entry priority: flush, then learn write, then aging
  always_ff @(posedge clk) begin
    if (!reset) begin
      ent_valid <= '0;
      for (int i = 0; i < DEPTH; i++) ent_age[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (flush) begin
          ent_valid[i] <= 1'b0;
          ent_age[i]   <= '0;
        end else if (wr_en && wr_idx == IDX_W'(i)) begin
          ent_valid[i] <= 1'b1;
          ent_age[i]   <= '0;
        end else if (age_tick && ent_valid[i]) begin
          if (ent_age[i] == AGE_MAX) begin
            ent_valid[i] <= 1'b0;
            ent_age[i]   <= '0;
          end else begin
            ent_age[i] <= ent_age[i] + 4'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      ent_mac[wr_idx]  <= smac_q;
      ent_port[wr_idx] <= src_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) entry_count <= '0;
    else        entry_count <= cnt_c;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= S_IDLE;
      req_ready     <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_port_mask <= '0;
      rsp_hit       <= 1'b0;
      dmac_q        <= '0;
      smac_q        <= '0;
      src_q         <= '0;
      dhit_q        <= 1'b0;
      shit_q        <= 1'b0;
      free_q        <= 1'b0;
      dport_q       <= '0;
      shit_idx_q    <= '0;
      free_idx_q    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            dmac_q    <= req_dmac;
            smac_q    <= req_smac;
            src_q     <= req_src_port;
            req_ready <= 1'b0;
            state     <= S_MATCH;
          end
        end
        S_MATCH: begin
          dhit_q     <= dhit_c;
          shit_q     <= shit_c;
          free_q     <= free_c;
          dport_q    <= dport_c;
          shit_idx_q <= shit_idx_c;
          free_idx_q <= free_idx_c;
          state      <= S_LEARN;
        end
        S_LEARN: begin
          rsp_port_mask <= mask_c;
          rsp_hit       <= hit_c;
          rsp_valid     <= 1'b1;
          state         <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fdb_learn_table.sv
// Bench for fdb_learn_table: directed vector table, corner sequences, then random traffic
// against a MAC-keyed associative-array reference model stepped once per clock edge.
module tb_fdb_learn_table;

  localparam int NP = 4;
  localparam int DEPTH = 16;
  localparam int AGE_LIMIT = 3;
  localparam logic [47:0] BCAST = 48'hffff_ffff_ffff;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [47:0] req_dmac, req_smac;
  logic [1:0]  req_src_port;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [3:0]  rsp_port_mask;
  logic        rsp_hit;
  logic        age_tick;
  logic        flush;
  logic        learn_drop;
  logic [6:0]  entry_count;

  int n_tests = 0;
  int n_fail  = 0;
  int drop_cnt = 0;

  always #5 clk = ~clk;

  fdb_learn_table #(.NPORTS(NP), .PORT_W(2), .DEPTH(DEPTH), .AGE_LIMIT(AGE_LIMIT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_dmac(req_dmac), .req_smac(req_smac), .req_src_port(req_src_port),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_port_mask(rsp_port_mask),
    .rsp_hit(rsp_hit), .age_tick(age_tick), .flush(flush), .learn_drop(learn_drop),
    .entry_count(entry_count)
  );

  // Reference model: table as MAC -> port / age maps; request progress as a stage number
  int m_port [bit [47:0]];
  int m_age  [bit [47:0]];
  int          stage = 0;
  bit          m_ready = 1'b0;
  bit          exp_valid = 1'b0, exp_hit = 1'b0;
  bit [3:0]    exp_mask = '0;
  int          exp_count = 0;
  bit [47:0]   s_dmac, s_smac;
  int          s_src;
  bit          snap_dhit, snap_shit, snap_free;
  int          snap_dport;

  function automatic bit is_mc(input bit [47:0] m);
    return m[40];
  endfunction

  function automatic bit learnable(input bit [47:0] m);
    return !is_mc(m) && (m != 48'h0);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit do_learn = 1'b0;
    bit [47:0] keys[$];
    int all_ports = (1 << NP) - 1;
    if (!reset) begin
      m_port.delete(); m_age.delete();
      stage = 0; m_ready = 1'b0; exp_valid = 1'b0; exp_hit = 1'b0;
      exp_mask = '0; exp_count = 0;
      return;
    end
    exp_count = m_port.num();
    case (stage)
      0: if (req_valid && m_ready) begin
           s_dmac = req_dmac; s_smac = req_smac; s_src = int'(req_src_port);
           stage = 1; m_ready = 1'b0;
         end else m_ready = 1'b1;
      1: begin
           snap_dhit  = m_port.exists(s_dmac);
           snap_dport = snap_dhit ? m_port[s_dmac] : 0;
           snap_shit  = m_port.exists(s_smac);
           snap_free  = m_port.num() < DEPTH;
           stage = 2;
         end
      2: begin
           if (is_mc(s_dmac) || !snap_dhit) begin
             exp_mask = 4'(all_ports & ~(1 << s_src)); exp_hit = 1'b0;
           end else begin
             exp_mask = (snap_dport == s_src) ? 4'h0 : 4'(1 << snap_dport); exp_hit = 1'b1;
           end
           exp_valid = 1'b1;
           stage = 3;
           do_learn = !flush && learnable(s_smac) && (snap_shit || snap_free);
         end
      default: if (rsp_ready) begin
           exp_valid = 1'b0; stage = 0; m_ready = 1'b1;
         end
    endcase
    if (flush) begin
      m_port.delete(); m_age.delete();
    end else begin
      if (age_tick) begin
        foreach (m_port[k]) keys.push_back(k);
        foreach (keys[j]) begin
          if (do_learn && keys[j] == s_smac) continue;
          if (m_age[keys[j]] == AGE_LIMIT - 1) begin
            m_port.delete(keys[j]); m_age.delete(keys[j]);
          end else m_age[keys[j]]++;
        end
      end
      if (do_learn) begin
        m_port[s_smac] = s_src; m_age[s_smac] = 0;
      end
    end
  endtask

  // Check outputs against the model (with current inputs applied), then advance one edge
  task automatic cyc();
    bit exp_drop;
    #1;
    exp_drop = reset && stage == 2 && learnable(s_smac) && !snap_shit && !snap_free && !flush;
    chk("req_ready", 64'(req_ready), 64'(m_ready));
    chk("rsp_valid", 64'(rsp_valid), 64'(exp_valid));
    chk("rsp_port_mask", 64'(rsp_port_mask), 64'(exp_mask));
    chk("rsp_hit", 64'(rsp_hit), 64'(exp_hit));
    chk("entry_count", 64'(entry_count), 64'(exp_count));
    chk("learn_drop", 64'(learn_drop), 64'(exp_drop));
    if (learn_drop === 1'b1) drop_cnt++;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_req(input bit [47:0] d, input bit [47:0] s, input int src,
                        input int tick_k, input int flush_k, input int hold,
                        output logic [3:0] mask, output logic hit, output int lat,
                        output int drops, output int leak);
    int guard = 0;
    int k = 0;
    int d0;
    while (!m_ready && guard < 20) begin cyc(); guard++; end
    d0 = drop_cnt; leak = 0;
    req_dmac = d; req_smac = s; req_src_port = 2'(src); req_valid = 1'b1;
    rsp_ready = (hold == 0);
    do begin
      age_tick = (k == tick_k); flush = (k == flush_k);
      cyc();
      if (k == 0) req_valid = 1'b0;
      k++;
    end while (!rsp_valid && k < 8);
    age_tick = 1'b0; flush = 1'b0; lat = k;
    for (int h = 0; h < hold; h++) begin
      if (req_ready) leak++;
      cyc();
    end
    mask = rsp_port_mask; hit = rsp_hit;
    rsp_ready = 1'b1;
    cyc();
    drops = drop_cnt - d0;
  endtask

  task automatic req_chk(input string nm, input bit [47:0] d, input bit [47:0] s, input int src,
                         input int tick_k, input int flush_k, input int hold,
                         input bit [3:0] emask, input bit ehit, input int edrops);
    logic [3:0] mask; logic hit; int lat, drops, leak;
    do_req(d, s, src, tick_k, flush_k, hold, mask, hit, lat, drops, leak);
    chk({nm, "_mask"}, 64'(mask), 64'(emask));
    chk({nm, "_hit"}, 64'(hit), 64'(ehit));
    chk({nm, "_latency"}, 64'(lat), 64'd3);
    chk({nm, "_drops"}, 64'(drops), 64'(edrops));
    if (hold > 0) chk({nm, "_ready_during_hold"}, 64'(leak), 64'd0);
  endtask

  task automatic tick();
    age_tick = 1'b1; cyc(); age_tick = 1'b0; cyc();
  endtask

  function automatic bit [47:0] pick_mac();
    int r = $urandom_range(0, 31);
    if (r < 24) return 48'h0200_0000_0000 | 48'(r);
    if (r < 28) return 48'h0100_0000_0000 | 48'(r);
    if (r < 30) return BCAST;
    return 48'h0;
  endfunction

  typedef struct {
    bit [47:0] dmac;
    bit [47:0] smac;
    int        src;
    bit [3:0]  mask;
    bit        hit;
    int        count;
  } vec_t;

  vec_t vt[7];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vt[0] = '{BCAST,              48'haa20_3040_5060, 1, 4'b1101, 1'b0, 1};
    vt[1] = '{48'haa20_3040_5060, 48'hffcc_bb44_0011, 2, 4'b0010, 1'b1, 1};
    vt[2] = '{48'haa20_3040_5060, 48'h0200_0000_0001, 1, 4'b0000, 1'b1, 2};
    vt[3] = '{48'h0200_0000_0001, 48'h0200_0000_0002, 3, 4'b0010, 1'b1, 3};
    vt[4] = '{48'h0300_0000_00aa, 48'haa20_3040_5060, 0, 4'b1110, 1'b0, 3};
    vt[5] = '{48'haa20_3040_5060, 48'h0000_0000_0000, 3, 4'b0001, 1'b1, 3};
    vt[6] = '{48'h1234_5678_9abc, 48'h0000_0000_0000, 2, 4'b1011, 1'b0, 3};

    reset = 1'b0; req_valid = 1'b0; req_dmac = '0; req_smac = '0; req_src_port = '0;
    rsp_ready = 1'b1; age_tick = 1'b0; flush = 1'b0;
    @(posedge clk); model_edge(); @(negedge clk);
    chk("reset_req_ready", 64'(req_ready), 64'd0);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_mask", 64'(rsp_port_mask), 64'd0);
    chk("reset_hit", 64'(rsp_hit), 64'd0);
    chk("reset_learn_drop", 64'(learn_drop), 64'd0);
    chk("reset_entry_count", 64'(entry_count), 64'd0);
    cyc();
    reset = 1'b1;
    cyc();
    chk("ready_after_reset", 64'(req_ready), 64'd1);

    foreach (vt[i]) begin
      req_chk($sformatf("vec%0d", i), vt[i].dmac, vt[i].smac, vt[i].src, -1, -1, 0,
              vt[i].mask, vt[i].hit, 0);
      chk($sformatf("vec%0d_count", i), 64'(entry_count), 64'(vt[i].count));
    end

    // Fill to capacity, then overflow
    flush = 1'b1; cyc(); flush = 1'b0; cyc();
    chk("flush_idle_count", 64'(entry_count), 64'd0);
    for (int i = 0; i < DEPTH; i++)
      req_chk("fill", BCAST, 48'h0200_0000_1000 + 48'(i), i % 4, -1, -1, 0,
              4'(4'hf & ~(4'h1 << (i % 4))), 1'b0, 0);
    chk("full_count", 64'(entry_count), 64'd16);
    req_chk("overflow", 48'h0200_0000_3000, 48'h0200_0000_2000, 2, -1, -1, 0, 4'b1011, 1'b0, 1);
    chk("overflow_count", 64'(entry_count), 64'd16);
    req_chk("full_flush_learn", BCAST, 48'h0200_0000_2001, 0, -1, 2, 0, 4'b1110, 1'b0, 0);
    chk("full_flush_count", 64'(entry_count), 64'd0);

    // Aging: two ticks survive, third expires
    req_chk("age_learn", BCAST, 48'h0200_0000_0055, 1, -1, -1, 0, 4'b1101, 1'b0, 0);
    tick(); tick();
    req_chk("age_2ticks", 48'h0200_0000_0055, 48'h0, 0, -1, -1, 0, 4'b0010, 1'b1, 0);
    tick(); cyc();
    chk("age_expired_count", 64'(entry_count), 64'd0);
    req_chk("age_3ticks", 48'h0200_0000_0055, 48'h0, 0, -1, -1, 0, 4'b1110, 1'b0, 0);
    // Refresh on the same edge as the expiring tick
    req_chk("age_relearn", BCAST, 48'h0200_0000_0055, 1, -1, -1, 0, 4'b1101, 1'b0, 0);
    tick(); tick();
    req_chk("age_refresh", BCAST, 48'h0200_0000_0055, 1, 2, -1, 0, 4'b1101, 1'b0, 0);
    tick(); tick();
    req_chk("age_survived", 48'h0200_0000_0055, 48'h0, 0, -1, -1, 0, 4'b0010, 1'b1, 0);
    chk("age_survived_count", 64'(entry_count), 64'd1);

    // Flush during LEARN: response still delivered, learn discarded
    req_chk("flush_learn", 48'h0200_0000_0055, 48'h0200_0000_0077, 2, -1, 2, 0, 4'b0010, 1'b1, 0);
    chk("flush_learn_count", 64'(entry_count), 64'd0);
    req_chk("flush_learn_gone", 48'h0200_0000_0077, 48'h0, 0, -1, -1, 0, 4'b1110, 1'b0, 0);

    // Response backpressure
    req_chk("hold", BCAST, 48'h0200_0000_00cc, 3, -1, -1, 10, 4'b0111, 1'b0, 0);

    // Reset during MATCH
    req_chk("rst_learn", BCAST, 48'h0200_0000_00aa, 3, -1, -1, 0, 4'b0111, 1'b0, 0);
    begin
      int late = 0;
      req_dmac = 48'h0200_0000_00aa; req_smac = 48'h0200_0000_00bb; req_src_port = 2'd0;
      req_valid = 1'b1; cyc(); req_valid = 1'b0;
      reset = 1'b0; cyc(); reset = 1'b1;
      chk("rst_mid_valid", 64'(rsp_valid), 64'd0);
      chk("rst_mid_ready", 64'(req_ready), 64'd0);
      chk("rst_mid_mask", 64'(rsp_port_mask), 64'd0);
      chk("rst_mid_count", 64'(entry_count), 64'd0);
      for (int i = 0; i < 6; i++) begin
        cyc();
        if (rsp_valid) late++;
      end
      chk("rst_no_response", 64'(late), 64'd0);
    end
    req_chk("rst_flood", 48'h0200_0000_00aa, 48'h0, 0, -1, -1, 0, 4'b1110, 1'b0, 0);

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      age_tick     = ($urandom_range(0, 14) == 0);
      flush        = ($urandom_range(0, 99) == 0);
      rsp_ready    = ($urandom_range(0, 3) != 0);
      req_valid    = ($urandom_range(0, 2) != 0);
      req_dmac     = pick_mac();
      req_smac     = pick_mac();
      req_src_port = 2'($urandom_range(0, 3));
      cyc();
    end
    req_valid = 1'b0; age_tick = 1'b0; flush = 1'b0; rsp_ready = 1'b1;
    repeat (6) cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
